// File: rtl/bcd_press_counter.sv
// Two-digit BCD up/down/clear press counter.
// Raw switches are synchronised, debounced and edge-detected before counting.
module bcd_press_counter #(
  parameter int DEBOUNCE_LIMIT = 250000
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Switch_Up,
  input  logic       i_Switch_Down,
  input  logic       i_Switch_Clr,
  output logic [3:0] o_Tens,
  output logic [3:0] o_Ones,
  output logic       o_Wrap
);

  localparam int CW = (DEBOUNCE_LIMIT > 2) ? $clog2(DEBOUNCE_LIMIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_LIMIT - 1);

  localparam int UP  = 0;
  localparam int DN  = 1;
  localparam int CLR = 2;

  logic [2:0]    raw;
  logic [2:0]    meta_q;
  logic [2:0]    sync_q;
  logic [2:0]    level_q;
  logic [2:0]    prev_q;
  logic [CW-1:0] cnt_q [3];
  logic [2:0]    press;

  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic       wrap_q, wrap_d;

  assign raw = {i_Switch_Clr, i_Switch_Down, i_Switch_Up};

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      meta_q  <= '0;
      sync_q  <= '0;
      level_q <= '0;
      prev_q  <= '0;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      meta_q <= raw;
      sync_q <= meta_q;
      prev_q <= level_q;
      // Level only moves after CNT_MAX+1 consecutive disagreeing samples.
      for (int i = 0; i < 3; i++) begin
        if (sync_q[i] != level_q[i]) begin
          if (cnt_q[i] == CNT_MAX) begin
            level_q[i] <= sync_q[i];
            cnt_q[i]   <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + CW'(1);
          end
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  assign press = level_q & ~prev_q;

  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    wrap_d = 1'b0;
    if (press[CLR]) begin
      tens_d = 4'd0;
      ones_d = 4'd0;
    end else if (press[UP] && !press[DN]) begin
      if (ones_q == 4'd9) begin
        ones_d = 4'd0;
        if (tens_q == 4'd9) begin
          tens_d = 4'd0;
          wrap_d = 1'b1;
        end else begin
          tens_d = tens_q + 4'd1;
        end
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end else if (press[DN] && !press[UP]) begin
      if (ones_q == 4'd0) begin
        ones_d = 4'd9;
        if (tens_q == 4'd0) begin
          tens_d = 4'd9;
          wrap_d = 1'b1;
        end else begin
          tens_d = tens_q - 4'd1;
        end
      end else begin
        ones_d = ones_q - 4'd1;
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      tens_q <= 4'd0;
      ones_q <= 4'd0;
      wrap_q <= 1'b0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
      wrap_q <= wrap_d;
    end
  end

  assign o_Tens = tens_q;
  assign o_Ones = ones_q;
  assign o_Wrap = wrap_q;

endmodule
